fifo_width_packer: RTL and testbench
====================================

Name: fifo_width_packer

Overview:
- Packs a stream of narrow FWFT words into wide words of RATIO lanes.
- Upstream side reads an FWFT FIFO (empty_n/read/dout); downstream side writes a relay_station/fifo (full_n/write/din).
- Sits in front of inter-slot relay stations so narrow producers can cross the floorplan on wide, low-rate channels.
- Optional flush emits a partially filled word.

Parameters:
- IN_WIDTH, 32, width of one input word (lane).
- RATIO, 4, input words per output word; must be >= 2.
- LANE_W, $clog2(RATIO+1), width of the lane-count output (derived, not overridden).

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_empty_n  input  1  upstream FWFT has data
- in_read  output  1  pop upstream word this cycle
- in_dout  input  IN_WIDTH  upstream head word
- out_full_n  input  1  downstream can accept
- out_write  output  1  output word valid / push
- out_din  output  IN_WIDTH*RATIO  packed word; lane k at bits [k*IN_WIDTH +: IN_WIDTH]
- out_lanes  output  LANE_W  valid lanes in out_din (RATIO for full word)
- flush  input  1  request emission of the partial word

Behaviour:
- Reset (reset low, asynchronous): lane counter cnt=0, accumulator=0, out_write=0, out_din=0, out_lanes=0, flush_pending=0. in_read is forced 0 while reset is low.
- Handshakes: an input transfer occurs when in_read && in_empty_n. An output transfer occurs when out_write && out_full_n. out_write/out_din/out_lanes are registered and held stable until transferred.
- slot_free = !out_write || out_full_n. This means the output register is empty or drains this cycle.
- in_read = in_empty_n && !flush_pending && (cnt < RATIO-1 || slot_free). It is combinational from registered state and in_empty_n/out_full_n only, never from flush.
- Accept, not last lane: write in_dout into lane cnt; cnt <= cnt+1.
- Accept, last lane (cnt == RATIO-1): on the next edge, load the output register with the accumulator plus in_dout in lane RATIO-1, and set out_lanes=RATIO, out_write=1, cnt=0. Clear the accumulator.
- Latency: the last lane accepted at edge N gives out_write=1 in the cycle after edge N. Sustained throughput is 1 input word per cycle when downstream never stalls.
- Flush: sampled on an edge with flush=1.
  - If cnt==0 and no accept that cycle, it is ignored.
  - Otherwise the partial word is emitted, with unused lanes zero and out_lanes = lanes filled, including a word accepted in the same cycle.
  - Flush in the same cycle as a last-lane accept is absorbed by the full word; no extra empty word is emitted.
  - If slot_free at that edge, the partial word is loaded immediately. Otherwise flush_pending=1 and input is stalled, and the partial word loads on the first edge where slot_free. Then flush_pending=0 and cnt=0.
- Output register: cleared (out_write=0) on transfer when nothing new loads. Back-to-back loads are allowed when out_full_n=1.
- Downstream stall: out_write held, out_din stable. Input continues filling lanes 0..RATIO-2, then in_read drops until slot_free.
- Upstream empty: no state change; a partial word waits indefinitely (no timeout).
- Reset mid-operation: all buffered data is discarded; no output after reset release until new input arrives.

Decomposition:
- Shared package: LANE_W computation function, and the lane-slice index helper (lane k -> bit offset).
- One sub-module, fifo_width_packer_out_reg: a single-entry output holding register with load/transfer/slot_free logic, parameterised by width. The top holds the lane counter, accumulator and flush_pending.

Test Plan:
- RATIO=4, IN_WIDTH=8. Push 0x11,0x22,0x33,0x44 back-to-back with out_full_n=1 -> one output 0x44332211, out_lanes=4, out_write high exactly one cycle after 0x44 is accepted.
- Continuous input 0x01..0x08 with out_full_n=1 -> outputs 0x04030201 then 0x08070605. in_read stays high all 8 cycles.
- Hold out_full_n=0 with one full word pending, then push 0xA1,0xA2,0xA3,0xA4 -> in_read drops after 0xA3. When out_full_n goes to 1, the held word transfers and 0xA4 is accepted in the same cycle. The next output is 0xA4A3A2A1.
- Push 0x55,0x66, then flush pulse -> output 0x00006655, out_lanes=2. Flush with cnt=0 and no input -> no output.
- Flush while out_write=1 and out_full_n=0, with cnt=3 -> in_read=0 until drain. The next output is the 3-lane partial word, out_lanes=3, followed by normal packing.
- Assert reset low asynchronously mid-word (cnt=2) and while out_write=1 -> out_write, out_din and out_lanes go to 0 immediately. After release, pushing 0x01..0x04 yields 0x04030201 with no residue.

Source files
------------

// File: rtl/fifo_width_packer_pkg.sv
// fifo_width_packer_pkg: sizing and lane-slice helpers shared by the packer files
package fifo_width_packer_pkg;
  function automatic int lane_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction
  function automatic int lane_off(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/fifo_width_packer_if.sv
// fifo_width_packer_if: FWFT read side, FIFO write side and flush of the packer
interface fifo_width_packer_if
  import fifo_width_packer_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO = 4,
  parameter int LANE_W = lane_w(RATIO)
);
  logic in_empty_n;
  logic in_read;
  logic [IN_WIDTH-1:0] in_dout;
  logic out_full_n;
  logic out_write;
  logic [IN_WIDTH*RATIO-1:0] out_din;
  logic [LANE_W-1:0] out_lanes;
  logic flush;
  modport master (
    output in_empty_n, in_dout, out_full_n, flush,
    input in_read, out_write, out_din, out_lanes
  );
  modport slave (
    input in_empty_n, in_dout, out_full_n, flush,
    output in_read, out_write, out_din, out_lanes
  );
endinterface

// File: rtl/fifo_width_packer_out_reg.sv
// fifo_width_packer_out_reg: single-entry output holding register, held stable until transferred
module fifo_width_packer_out_reg #(
  parameter int W = 32,
  parameter int LW = 3
) (
  input logic clk,
  input logic reset,
  input logic load,
  input logic [W-1:0] load_data,
  input logic [LW-1:0] load_lanes,
  input logic full_n,
  output logic out_write,
  output logic [W-1:0] out_din,
  output logic [LW-1:0] out_lanes,
  output logic slot_free
);
  assign slot_free = !out_write || full_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_write <= 1'b0;
      out_din <= '0;
      out_lanes <= '0;
    end else if (load) begin
      out_write <= 1'b1;
      out_din <= load_data;
      out_lanes <= load_lanes;
    end else if (full_n) begin
      out_write <= 1'b0;
    end
endmodule

// File: rtl/fifo_width_packer.sv
// fifo_width_packer: packs RATIO narrow FWFT words into one wide word, with flush of partial words
module fifo_width_packer
  import fifo_width_packer_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO = 4
) (
  input logic clk,
  input logic reset,
  fifo_width_packer_if.slave bus
);
  localparam int LANE_W = lane_w(RATIO);
  localparam int out_w = IN_WIDTH * RATIO;
  localparam logic [LANE_W-1:0] last_lane = LANE_W'(RATIO - 1);
  logic [LANE_W-1:0] cnt, filled;
  logic [out_w-1:0] acc, acc_next;
  logic flush_pending, slot_free, accept, last, flush_req, load;
  assign accept = reset && bus.in_empty_n && !flush_pending && (cnt < last_lane || slot_free);
  assign bus.in_read = accept;
  assign last = accept && cnt == last_lane;
  assign filled = cnt + LANE_W'(accept);
  // a flush coinciding with the last lane rides on the full word
  assign flush_req = bus.flush && (cnt != '0 || accept) && !last;
  assign load = last || ((flush_req || flush_pending) && slot_free);
  always_comb begin
    acc_next = acc;
    if (accept) acc_next[lane_off(int'(cnt), IN_WIDTH) +: IN_WIDTH] = bus.in_dout;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
      flush_pending <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
      flush_pending <= 1'b0;
    end else begin
      cnt <= filled;
      acc <= acc_next;
      flush_pending <= flush_pending || flush_req;
    end
  fifo_width_packer_out_reg #(.W(out_w), .LW(LANE_W)) u_out_reg (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_data(acc_next),
    .load_lanes(filled),
    .full_n(bus.out_full_n),
    .out_write(bus.out_write),
    .out_din(bus.out_din),
    .out_lanes(bus.out_lanes),
    .slot_free(slot_free)
  );
endmodule

// File: tb/tb_fifo_width_packer.sv
// tb_fifo_width_packer: cycle-by-cycle vector table plus hand-written reset sequences
module tb_fifo_width_packer;
  typedef struct {
    logic e;
    logic [7:0] d;
    logic f;
    logic fl;
    logic r;
    logic w;
    logic [31:0] din;
    logic [2:0] lanes;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t v[$];
  fifo_width_packer_if #(.IN_WIDTH(8), .RATIO(4)) bus ();
  fifo_width_packer #(.IN_WIDTH(8), .RATIO(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic add(input logic e, input logic [7:0] d, input logic f, input logic fl,
                     input logic r, input logic w, input logic [31:0] din, input logic [2:0] lanes);
    vec_t x;
    x.e = e; x.d = d; x.f = f; x.fl = fl; x.r = r; x.w = w; x.din = din; x.lanes = lanes;
    v.push_back(x);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic e, input logic [7:0] d, input logic f, input logic fl);
    bus.in_empty_n = e;
    bus.in_dout = d;
    bus.out_full_n = f;
    bus.flush = fl;
  endtask
  initial begin
    drive(1, 8'h00, 1, 0);
    #1;
    chk("rst_in_read", {31'b0, bus.in_read}, 0);
    chk("rst_write", {31'b0, bus.out_write}, 0);
    chk("rst_din", bus.out_din, 0);
    chk("rst_lanes", {29'b0, bus.out_lanes}, 0);
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    // full word, latency one cycle after last lane
    add(1, 8'h11, 1, 0, 1, 0, 0, 0);
    add(1, 8'h22, 1, 0, 1, 0, 0, 0);
    add(1, 8'h33, 1, 0, 1, 0, 0, 0);
    add(1, 8'h44, 1, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 32'h44332211, 4);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 8'(i), 1, 0, 1, i == 5, i == 5 ? 32'h04030201 : 0, i == 5 ? 3'd4 : 3'd0);
    add(0, 8'h00, 1, 0, 0, 1, 32'h08070605, 4);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    // downstream stall with a full word held
    add(1, 8'h91, 1, 0, 1, 0, 0, 0);
    add(1, 8'h92, 1, 0, 1, 0, 0, 0);
    add(1, 8'h93, 1, 0, 1, 0, 0, 0);
    add(1, 8'h94, 1, 0, 1, 0, 0, 0);
    add(1, 8'hA1, 0, 0, 1, 1, 32'h94939291, 4);
    add(1, 8'hA2, 0, 0, 1, 1, 32'h94939291, 4);
    add(1, 8'hA3, 0, 0, 1, 1, 32'h94939291, 4);
    add(1, 8'hA4, 0, 0, 0, 1, 32'h94939291, 4);
    add(1, 8'hA4, 0, 0, 0, 1, 32'h94939291, 4);
    add(1, 8'hA4, 1, 0, 1, 1, 32'h94939291, 4);
    add(0, 8'h00, 1, 0, 0, 1, 32'hA4A3A2A1, 4);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    // flush of a two-lane word, then an ignored flush
    add(1, 8'h55, 1, 0, 1, 0, 0, 0);
    add(1, 8'h66, 1, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 32'h00006655, 2);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    // flush together with the only accepted word, then with a last lane
    add(1, 8'h77, 1, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 32'h00000077, 1);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(1, 8'h81, 1, 0, 1, 0, 0, 0);
    add(1, 8'h82, 1, 0, 1, 0, 0, 0);
    add(1, 8'h83, 1, 0, 1, 0, 0, 0);
    add(1, 8'h84, 1, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 32'h84838281, 4);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    // flush while the output is stalled with cnt=3
    add(1, 8'hB1, 1, 0, 1, 0, 0, 0);
    add(1, 8'hB2, 1, 0, 1, 0, 0, 0);
    add(1, 8'hB3, 1, 0, 1, 0, 0, 0);
    add(1, 8'hB4, 1, 0, 1, 0, 0, 0);
    add(1, 8'hC1, 0, 0, 1, 1, 32'hB4B3B2B1, 4);
    add(1, 8'hC2, 0, 0, 1, 1, 32'hB4B3B2B1, 4);
    add(1, 8'hC3, 0, 0, 1, 1, 32'hB4B3B2B1, 4);
    add(1, 8'hC4, 0, 1, 0, 1, 32'hB4B3B2B1, 4);
    add(1, 8'hC4, 0, 0, 0, 1, 32'hB4B3B2B1, 4);
    add(1, 8'hC4, 1, 0, 0, 1, 32'hB4B3B2B1, 4);
    add(1, 8'hC4, 1, 0, 1, 1, 32'h00C3C2C1, 3);
    add(1, 8'hD1, 1, 0, 1, 0, 0, 0);
    add(1, 8'hD2, 1, 0, 1, 0, 0, 0);
    add(1, 8'hD3, 1, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 1, 32'hD3D2D1C4, 4);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    foreach (v[i]) begin
      @(negedge clk);
      drive(v[i].e, v[i].d, v[i].f, v[i].fl);
      #1;
      chk($sformatf("vec%0d_in_read", i), {31'b0, bus.in_read}, {31'b0, v[i].r});
      chk($sformatf("vec%0d_write", i), {31'b0, bus.out_write}, {31'b0, v[i].w});
      if (v[i].w) begin
        chk($sformatf("vec%0d_din", i), bus.out_din, v[i].din);
        chk($sformatf("vec%0d_lanes", i), {29'b0, bus.out_lanes}, {29'b0, v[i].lanes});
      end
    end
    // asynchronous reset with a word held and two lanes buffered
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1, 8'(8'h11 * i), 1, 0);
    end
    @(negedge clk);
    drive(1, 8'h55, 0, 0);
    @(negedge clk);
    drive(1, 8'h66, 0, 0);
    @(negedge clk);
    drive(0, 8'h00, 0, 0);
    #1;
    chk("pre_rst_write", {31'b0, bus.out_write}, 1);
    chk("pre_rst_din", bus.out_din, 32'h44332211);
    reset = 1'b0;
    #1;
    chk("mid_rst_write", {31'b0, bus.out_write}, 0);
    chk("mid_rst_din", bus.out_din, 0);
    chk("mid_rst_lanes", {29'b0, bus.out_lanes}, 0);
    bus.in_empty_n = 1'b1;
    #1;
    chk("mid_rst_in_read", {31'b0, bus.in_read}, 0);
    @(negedge clk);
    drive(0, 8'h00, 1, 0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_write", {31'b0, bus.out_write}, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1, 8'(i), 1, 0);
    end
    @(negedge clk);
    drive(0, 8'h00, 1, 0);
    #1;
    chk("post_rst_word_write", {31'b0, bus.out_write}, 1);
    chk("post_rst_word_din", bus.out_din, 32'h04030201);
    chk("post_rst_word_lanes", {29'b0, bus.out_lanes}, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
